// File: rtl/tetris_timing_pkg.sv
// Shared timing definitions for the falling-piece logic: FSM states, the
// per-level fall periods in 10 ms ticks, and the soft-drop period.
package tetris_timing_pkg;

  localparam int CNT_W           = 7;
  localparam int NUM_LEVELS      = 16;
  localparam int SOFT_DROP_TICKS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LEVEL_PERIOD [NUM_LEVELS] = '{
    7'd80, 7'd72, 7'd63, 7'd55, 7'd47, 7'd38, 7'd30, 7'd22,
    7'd17, 7'd13, 7'd10, 7'd8,  7'd7,  7'd6,  7'd5,  7'd4
  };

endpackage

// File: rtl/level_period_lut.sv
// Maps game level and soft-drop to the fall period in ticks. Purely
// combinational; also used by the HUD speed display.
module level_period_lut
  import tetris_timing_pkg::*;
#(
  parameter int LEVEL_W = 4,
  parameter int CNT_W   = tetris_timing_pkg::CNT_W
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  output logic [CNT_W-1:0]   period
);

  localparam int IDX_W = $clog2(NUM_LEVELS);

  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] base;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    idx = '1;
    if (int'(level) < NUM_LEVELS) idx = IDX_W'(level);
    base   = CNT_W'(LEVEL_PERIOD[idx]);
    period = base;
    // Soft drop only ever speeds the piece up, never slows it down.
    if (soft_drop && (base > CNT_W'(SOFT_DROP_TICKS))) period = CNT_W'(SOFT_DROP_TICKS);
  end

endmodule

// File: rtl/gravity_timer.sv
// Counts 10 ms ticks and holds a drop request to the movement FSM each time
// the current piece is due to fall one row.
module gravity_timer
  import tetris_timing_pkg::*;
#(
  parameter int LEVEL_W = 4,
  parameter int CNT_W   = tetris_timing_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms10,
  input  logic               enable,
  input  logic               restart,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic [CNT_W-1:0]   ticks_left
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] period;
  logic             drop_req_q, drop_req_d;
  logic [CNT_W-1:0] ticks_left_q, ticks_left_d;

  level_period_lut #(
    .LEVEL_W (LEVEL_W),
    .CNT_W   (CNT_W)
  ) u_period_lut (
    .level     (level),
    .soft_drop (soft_drop),
    .period    (period)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drop_req_q   <= 1'b0;
      ticks_left_q <= CNT_W'(LEVEL_PERIOD[0]);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drop_req_q   <= drop_req_d;
      ticks_left_q <= ticks_left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    if (!enable) begin
      // Pausing mid-count keeps progress; pausing on a request discards it.
      state_d = IDLE;
      if (state_q == REQ) cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = COUNT;
        COUNT: begin
          if (restart) begin
            cnt_d = '0;
          end else if (ms10) begin
            // >= so a period shortened mid-count fires on the next tick.
            if (cnt_inc >= {1'b0, period}) begin
              state_d = REQ;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
          end
        end
        REQ: begin
          if (drop_ack) begin
            state_d = COUNT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    drop_req_d   = (state_d == REQ);
    ticks_left_d = '0;
    if ((state_d != REQ) && (period > cnt_d)) ticks_left_d = period - cnt_d;
  end

  assign drop_req   = drop_req_q;
  assign ticks_left = ticks_left_q;

endmodule

// File: tb/tb_gravity_timer.sv
// Self-checking bench for gravity_timer: a behavioural model pushes the
// expected outputs each cycle, popped and compared one edge later.
module tb_gravity_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ms10 = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       drop_ack = 1'b0;
  logic       drop_req;
  logic [6:0] ticks_left;

  gravity_timer #(.LEVEL_W(4), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .ms10       (ms10),
    .enable     (enable),
    .restart    (restart),
    .level      (level),
    .soft_drop  (soft_drop),
    .drop_ack   (drop_ack),
    .drop_req   (drop_req),
    .ticks_left (ticks_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [6:0] tl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int periods [16] = '{80, 72, 63, 55, 47, 38, 30, 22, 17, 13, 10, 8, 7, 6, 5, 4};
  int m_state = 0; // 0 paused, 1 counting, 2 request pending
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge given the inputs currently driven.
  task automatic model_step(output exp_t e);
    int p;
    p = periods[level];
    if (soft_drop && p > 3) p = 3;
    if (reset) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (!enable) begin
      if (m_state == 2) m_cnt = 0;
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (restart) m_cnt = 0;
      else if (ms10) begin
        if (m_cnt + 1 >= p) begin
          m_state = 2;
          m_cnt   = 0;
        end else m_cnt = m_cnt + 1;
      end
    end else if (drop_ack) begin
      m_state = 1;
      m_cnt   = 0;
    end
    e.req = (m_state == 2);
    if (reset) e.tl = 7'd80;
    else if (m_state == 2 || p <= m_cnt) e.tl = 7'd0;
    else e.tl = 7'(p - m_cnt);
  endtask

  task automatic step();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("sb_req", drop_req, e.req);
      check("sb_tl", ticks_left, e.tl);
    end
  endtask

  // n tick pulses, one every 4 clocks.
  task automatic pulse(input int n);
    repeat (n) begin
      ms10 = 1'b1;
      step();
      ms10 = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic do_ack();
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("rst_req", drop_req, 1'b0);
    check("rst_tl", ticks_left, 7'd80);
    reset  = 1'b0;
    enable = 1'b1;
    step();
    do_restart();

    // Level 0: request after the 80th pulse, held with no backlog.
    pulse(79);
    check("pre80_req", drop_req, 1'b0);
    check("pre80_tl", ticks_left, 7'd1);
    ms10 = 1'b1;
    step();
    ms10 = 1'b0;
    check("rise80_req", drop_req, 1'b1);
    check("rise80_tl", ticks_left, 7'd0);
    repeat (3) step();
    pulse(20);
    check("held_req", drop_req, 1'b1);
    do_ack();
    check("ack_req", drop_req, 1'b0);
    check("ack_tl", ticks_left, 7'd80);
    pulse(79);
    check("second_pre_req", drop_req, 1'b0);
    pulse(1);
    check("second_req", drop_req, 1'b1);
    do_ack();

    // Level 10, soft drop pressed after two ticks.
    level = 4'd10;
    do_restart();
    pulse(2);
    check("l10_tl", ticks_left, 7'd8);
    soft_drop = 1'b1;
    step();
    check("soft_tl", ticks_left, 7'd1);
    pulse(1);
    check("soft_req", drop_req, 1'b1);
    do_ack();
    check("soft_ack_tl", ticks_left, 7'd3);
    level = 4'd15;
    step();
    check("l15_soft_tl", ticks_left, 7'd3);
    soft_drop = 1'b0;
    step();
    check("l15_tl", ticks_left, 7'd4);

    // Level jump 0 -> 15 with cnt = 40.
    level = 4'd0;
    do_restart();
    pulse(40);
    check("cnt40_tl", ticks_left, 7'd40);
    level = 4'd15;
    step();
    check("jump_tl_sat", ticks_left, 7'd0);
    check("jump_noreq", drop_req, 1'b0);
    pulse(1);
    check("jump_req", drop_req, 1'b1);
    do_restart();
    check("req_restart_req", drop_req, 1'b1);
    check("req_restart_tl", ticks_left, 7'd0);
    do_ack();

    // Restart beats ms10; stray ack ignored.
    level = 4'd0;
    do_restart();
    pulse(10);
    check("cnt10_tl", ticks_left, 7'd70);
    do_ack();
    check("stray_ack_tl", ticks_left, 7'd70);
    ms10    = 1'b1;
    restart = 1'b1;
    step();
    ms10    = 1'b0;
    restart = 1'b0;
    check("restart_ms10_tl", ticks_left, 7'd80);
    pulse(1);
    check("after_restart_tl", ticks_left, 7'd79);

    // Pause in COUNT holds cnt; pause in REQ discards the request.
    do_restart();
    pulse(30);
    check("cnt30_tl", ticks_left, 7'd50);
    enable = 1'b0;
    step();
    pulse(50);
    check("pause_req", drop_req, 1'b0);
    check("pause_tl", ticks_left, 7'd50);
    enable = 1'b1;
    step();
    pulse(1);
    check("resume_tl", ticks_left, 7'd49);
    level = 4'd15;
    pulse(1);
    check("pre_pause_req", drop_req, 1'b1);
    enable = 1'b0;
    step();
    check("pause_req_drop", drop_req, 1'b0);
    check("pause_req_tl", ticks_left, 7'd4);
    enable = 1'b1;
    step();
    pulse(3);
    check("resume0_tl", ticks_left, 7'd1);
    check("resume0_noreq", drop_req, 1'b0);
    pulse(1);
    check("resume0_req", drop_req, 1'b1);

    // Reset while a request is pending.
    reset = 1'b1;
    step();
    check("rst_req_drop", drop_req, 1'b0);
    check("rst_req_tl", ticks_left, 7'd80);
    reset = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
